camera_capture_sequencer: RTL and testbench
===========================================

# camera_capture_sequencer

Sequences a single-frame camera capture from a start command to image-ready. Wakes the D-PHY from power save and flushes the image pipeline, then gates the debayer/JPEG datapath for exactly one complete sensor frame. Waits for the encoder to finish and latches the compressed size for the SPI register block. Sits between the SPI register block (start/power-save/status) and the camera datapath (frame timing, pipeline enable, encoder done).

## Interface
Parameters:
- SETTLE_CYCLES, 1000: D-PHY power-up settle time in clocks, ≥1
- FLUSH_CYCLES, 4: pipeline reset pulse length in clocks, ≥1
- TIMEOUT_CYCLES, 4194304: max clocks from end of flush to encoder done, ≥2

Ports:
- clock_in  in  1  single clock; all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- start_capture_in  in  1  one-cycle start pulse
- power_save_enable_in  in  1  level; request D-PHY power-down when idle
- frame_valid_in  in  1  sensor frame-valid level, synchronous to clock_in
- jpeg_done_in  in  1  one-cycle pulse: encoder finished writing buffer
- jpeg_size_in  in  16  compressed byte count, valid with jpeg_done_in
- dphy_power_down_out  out  1  D-PHY power-down request
- pipeline_reset_out  out  1  flush pulse to debayer/JPEG pipeline
- pipeline_enable_out  out  1  datapath gate, high for exactly one frame
- busy_out  out  1  high whenever state ≠ IDLE
- image_ready_out  out  1  capture complete, buffer valid
- image_size_out  out  16  latched jpeg_size_in
- timeout_out  out  1  sticky: last capture aborted by timeout

## Operation
States: IDLE, WAKE, FLUSH, WAIT_FRAME_END, WAIT_FRAME_START, CAPTURE, ENCODE.
- IDLE: dphy_power_down_out = power_save_enable_in (registered). On start_capture_in: clear image_ready_out and timeout_out. Go to WAKE if dphy_power_down_out = 1, else FLUSH.
- WAKE: dphy_power_down_out = 0; count SETTLE_CYCLES, then FLUSH.
- FLUSH: pipeline_reset_out = 1 for FLUSH_CYCLES, then WAIT_FRAME_END. Timeout counter loads TIMEOUT_CYCLES on exit.
- WAIT_FRAME_END: wait for frame_valid_in = 0, so a frame already in progress is never captured.
- WAIT_FRAME_START: on frame_valid_in = 1, go to CAPTURE.
- CAPTURE: on frame_valid_in = 0, go to ENCODE.
- ENCODE: on jpeg_done_in: latch image_size_out ← jpeg_size_in, set image_ready_out, go to IDLE.
- pipeline_enable_out is combinational: (WAIT_FRAME_START & frame_valid_in) | (CAPTURE & frame_valid_in). It covers every frame_valid_in-high cycle of the captured frame and no other cycle.
- Timeout: counter decrements in WAIT_FRAME_END, WAIT_FRAME_START, CAPTURE and ENCODE. On reaching 0: set timeout_out, go to IDLE, leave image_ready_out = 0 and image_size_out unchanged.
- Boundary rules:
  - start_capture_in while busy: abort the current capture, clear image_ready_out/timeout_out, go to FLUSH. WAKE is skipped because the PHY is already up.
  - jpeg_done_in outside ENCODE: ignored; image_size_out is not updated.
  - jpeg_done_in in the same cycle the timeout expires: done wins, timeout_out stays 0.
  - power_save_enable_in changes while busy: ignored until IDLE. dphy_power_down_out is held 0 in every non-IDLE state.
  - start_capture_in in the same cycle as reset_in: reset wins.
  - Counters do not wrap. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates at 0.

## Timing
- Reset values: all outputs 0, image_size_out = 0, state IDLE. The PHY is powered by default.
- Start pulse sampled at edge N: busy_out = 1 and state ≠ IDLE from N+1.
- Without power save, pipeline_reset_out is high for cycles N+1 … N+FLUSH_CYCLES.
- With power save, dphy_power_down_out falls at N+1. Flush then starts at N+1+SETTLE_CYCLES.
- Frame edges:
  - pipeline_enable_out rises combinationally in the first cycle frame_valid_in = 1 in WAIT_FRAME_START.
  - It falls in the first cycle frame_valid_in = 0.
- jpeg_done_in sampled at edge M in ENCODE:
  - image_ready_out = 1 and image_size_out valid from M+1.
  - busy_out = 0 from M+1.
- dphy_power_down_out re-asserts one cycle after return to IDLE if power_save_enable_in = 1.

## Test plan
Bench parameters: SETTLE_CYCLES=8, FLUSH_CYCLES=4, TIMEOUT_CYCLES=1000.
- Basic capture, power save off: start at cycle 10; frame_valid low 20 cycles, high 100, low; jpeg_done with size 0x1234 at 40 cycles after frame end. Require flush 11–14, enable high for exactly those 100 cycles, image_ready=1 and image_size=0x1234 at the next cycle, busy low.
- Mid-frame start: frame_valid already high at start. Require enable stays 0 for the rest of that frame and covers only the next full frame.
- Power save: power_save_enable=1 while idle → dphy_power_down_out=1. Start → power-down falls next cycle, flush begins 8 cycles later. After done, power-down re-asserts.
- Timeout: start with no frame_valid activity. Require timeout_out=1 and busy_out=0 exactly 1000 cycles after flush ends, image_ready=0. Repeat with jpeg_done on the expiry cycle → image_ready=1, timeout_out=0.
- Restart while busy: second start during CAPTURE → pipeline_reset pulses 4 cycles, enable drops, the next full frame is captured. Stray jpeg_done in WAIT_FRAME_START is ignored, image_size unchanged.
- Reset mid-ENCODE: reset_in for 1 cycle → all outputs 0 next cycle. A subsequent jpeg_done is ignored.

Source files
------------

// File: rtl/camera_capture_sequencer.sv
// ---------------------------------------------------------------------------
// camera_capture_sequencer
//
// Sequences one single-frame camera capture, from a start command to
// image-ready. On a start pulse it wakes the D-PHY if it was powered down,
// flushes the debayer/JPEG pipeline, and then opens the datapath gate for
// exactly one complete sensor frame. It then waits for the encoder to finish
// and latches the compressed size for the SPI register block. A watchdog
// bounds everything after the flush, so a missing sensor or encoder can
// never leave the block busy forever.
//
// Parameters:
//   SETTLE_CYCLES   D-PHY power-up settle time in clocks (>= 1)
//   FLUSH_CYCLES    length of the pipeline reset pulse in clocks (>= 1)
//   TIMEOUT_CYCLES  clock budget from the end of the flush to encoder done (>= 2)
//
// Ports:
//   clock_in              single clock, all logic on the rising edge
//   reset_in              synchronous active-high reset
//   start_capture_in      one-cycle start pulse (restarts a running capture)
//   power_save_enable_in  level, asks for D-PHY power-down while idle
//   frame_valid_in        sensor frame-valid level, already in this clock domain
//   jpeg_done_in          one-cycle pulse, encoder finished writing the buffer
//   jpeg_size_in[15:0]    compressed byte count, valid with jpeg_done_in
//   dphy_power_down_out   D-PHY power-down request (only ever high while idle)
//   pipeline_reset_out    flush pulse to the debayer/JPEG pipeline
//   pipeline_enable_out   datapath gate, high for every valid cycle of one frame
//   busy_out              high whenever a capture is in progress
//   image_ready_out       capture complete, buffer contents valid
//   image_size_out[15:0]  latched jpeg_size_in from the last good capture
//   timeout_out           sticky, the last capture was aborted by the watchdog
// ---------------------------------------------------------------------------
module camera_capture_sequencer #(
   parameter int SETTLE_CYCLES  = 1000,
   parameter int FLUSH_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 4194304
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        start_capture_in,
   input  logic        power_save_enable_in,
   input  logic        frame_valid_in,
   input  logic        jpeg_done_in,
   input  logic [15:0] jpeg_size_in,
   output logic        dphy_power_down_out,
   output logic        pipeline_reset_out,
   output logic        pipeline_enable_out,
   output logic        busy_out,
   output logic        image_ready_out,
   output logic [15:0] image_size_out,
   output logic        timeout_out
);

   // The settle and flush phases never overlap, so they share one down-counter
   // sized for the longer of the two.
   localparam int PHASE_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);

   // Phase counters are loaded with length-1 so that the phase occupies
   // exactly the requested number of cycles, ending on the cycle it reads 0.
   localparam logic [PHASE_W-1:0] SETTLE_LOAD = PHASE_W'(SETTLE_CYCLES - 1);
   localparam logic [PHASE_W-1:0] FLUSH_LOAD  = PHASE_W'(FLUSH_CYCLES - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE   = PHASE_W'(1);
   localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAKE,
      ST_FLUSH,
      ST_WAIT_FRAME_END,
      ST_WAIT_FRAME_START,
      ST_CAPTURE,
      ST_ENCODE
   } state_t;

   state_t               state;
   logic [PHASE_W-1:0]   phase_cnt;
   logic [TIMER_W-1:0]   timer;
   logic                 timer_expiring;
   logic [TIMER_W-1:0]   timer_next;

   // The watchdog expires on the edge where it would step from 1 to 0. The
   // "<=" also covers a counter that somehow sits at 0, so the FSM can never
   // wedge in a wait state. The counter saturates at 0 rather than wrapping.
   always_comb begin
      timer_expiring = (timer <= TIMER_ONE);
      timer_next     = (timer != '0) ? (timer - TIMER_ONE) : '0;
   end

   // The gate is decoded combinationally from frame_valid_in so it rises in
   // the very first valid cycle of the captured frame; a registered version
   // would lose that first line. WAIT_FRAME_END is deliberately excluded so a
   // frame already in flight when the flush ended is never passed through.
   always_comb begin
      pipeline_enable_out = frame_valid_in &
                            ((state == ST_WAIT_FRAME_START) || (state == ST_CAPTURE));
   end

   // Main sequencer. All status outputs are registered here alongside the
   // state so they change in lock-step with it. A start pulse from any busy
   // state aborts and re-flushes, skipping WAKE because the PHY is already
   // powered whenever the FSM is out of IDLE. jpeg_done_in is checked before
   // the watchdog in ENCODE so a completion on the expiry cycle still counts.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state               <= ST_IDLE;
         phase_cnt           <= '0;
         timer               <= '0;
         dphy_power_down_out <= 1'b0;
         pipeline_reset_out  <= 1'b0;
         busy_out            <= 1'b0;
         image_ready_out     <= 1'b0;
         image_size_out      <= '0;
         timeout_out         <= 1'b0;
      end else begin
         dphy_power_down_out <= 1'b0;

         if (start_capture_in && (state != ST_IDLE)) begin
            state              <= ST_FLUSH;
            phase_cnt          <= FLUSH_LOAD;
            pipeline_reset_out <= 1'b1;
            image_ready_out    <= 1'b0;
            timeout_out        <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  dphy_power_down_out <= power_save_enable_in;
                  if (start_capture_in) begin
                     dphy_power_down_out <= 1'b0;
                     busy_out            <= 1'b1;
                     image_ready_out     <= 1'b0;
                     timeout_out         <= 1'b0;
                     if (dphy_power_down_out) begin
                        state     <= ST_WAKE;
                        phase_cnt <= SETTLE_LOAD;
                     end else begin
                        state              <= ST_FLUSH;
                        phase_cnt          <= FLUSH_LOAD;
                        pipeline_reset_out <= 1'b1;
                     end
                  end
               end

               ST_WAKE: begin
                  if (phase_cnt == '0) begin
                     state              <= ST_FLUSH;
                     phase_cnt          <= FLUSH_LOAD;
                     pipeline_reset_out <= 1'b1;
                  end else begin
                     phase_cnt <= phase_cnt - PHASE_ONE;
                  end
               end

               ST_FLUSH: begin
                  if (phase_cnt == '0) begin
                     state              <= ST_WAIT_FRAME_END;
                     pipeline_reset_out <= 1'b0;
                     timer              <= TIMER_LOAD;
                  end else begin
                     phase_cnt <= phase_cnt - PHASE_ONE;
                  end
               end

               ST_WAIT_FRAME_END: begin
                  timer <= timer_next;
                  if (timer_expiring) begin
                     state       <= ST_IDLE;
                     busy_out    <= 1'b0;
                     timeout_out <= 1'b1;
                  end else if (!frame_valid_in) begin
                     state <= ST_WAIT_FRAME_START;
                  end
               end

               ST_WAIT_FRAME_START: begin
                  timer <= timer_next;
                  if (timer_expiring) begin
                     state       <= ST_IDLE;
                     busy_out    <= 1'b0;
                     timeout_out <= 1'b1;
                  end else if (frame_valid_in) begin
                     state <= ST_CAPTURE;
                  end
               end

               ST_CAPTURE: begin
                  timer <= timer_next;
                  if (timer_expiring) begin
                     state       <= ST_IDLE;
                     busy_out    <= 1'b0;
                     timeout_out <= 1'b1;
                  end else if (!frame_valid_in) begin
                     state <= ST_ENCODE;
                  end
               end

               ST_ENCODE: begin
                  timer <= timer_next;
                  if (jpeg_done_in) begin
                     state           <= ST_IDLE;
                     busy_out        <= 1'b0;
                     image_ready_out <= 1'b1;
                     image_size_out  <= jpeg_size_in;
                  end else if (timer_expiring) begin
                     state       <= ST_IDLE;
                     busy_out    <= 1'b0;
                     timeout_out <= 1'b1;
                  end
               end

               default: begin
                  state              <= ST_IDLE;
                  busy_out           <= 1'b0;
                  pipeline_reset_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_camera_capture_sequencer
//
// Each scenario fills a per-cycle stimulus table (randomized lengths, gaps
// and sizes), plays it into the sequencer, records every output per cycle,
// and compares the recorded traces against windows computed from the
// capture rules with plain arithmetic.
//
// Cycle indexing: stimulus entry k is applied during cycle k and sampled at
// the following rising edge, so a registered reaction shows up in trace k+1
// while pipeline_enable_out reacts in trace k itself.
// ---------------------------------------------------------------------------
module tb_camera_capture_sequencer;

   localparam int S    = 8;
   localparam int F    = 4;
   localparam int T    = 1000;
   localparam int MAXC = 4096;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        start_capture_in = 1'b0;
   logic        power_save_enable_in = 1'b0;
   logic        frame_valid_in = 1'b0;
   logic        jpeg_done_in = 1'b0;
   logic [15:0] jpeg_size_in = '0;
   logic        dphy_power_down_out;
   logic        pipeline_reset_out;
   logic        pipeline_enable_out;
   logic        busy_out;
   logic        image_ready_out;
   logic [15:0] image_size_out;
   logic        timeout_out;

   int checks   = 0;
   int failures = 0;

   logic        st_rst   [0:MAXC-1];
   logic        st_start [0:MAXC-1];
   logic        st_ps    [0:MAXC-1];
   logic        st_fv    [0:MAXC-1];
   logic        st_jd    [0:MAXC-1];
   logic [15:0] st_size  [0:MAXC-1];

   logic [MAXC-1:0] tr_dphy, tr_prst, tr_en, tr_busy, tr_ready, tr_tmo;
   logic [15:0]     tr_size [0:MAXC-1];

   camera_capture_sequencer #(
      .SETTLE_CYCLES (S),
      .FLUSH_CYCLES  (F),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clock_in            (clock_in),
      .reset_in            (reset_in),
      .start_capture_in    (start_capture_in),
      .power_save_enable_in(power_save_enable_in),
      .frame_valid_in      (frame_valid_in),
      .jpeg_done_in        (jpeg_done_in),
      .jpeg_size_in        (jpeg_size_in),
      .dphy_power_down_out (dphy_power_down_out),
      .pipeline_reset_out  (pipeline_reset_out),
      .pipeline_enable_out (pipeline_enable_out),
      .busy_out            (busy_out),
      .image_ready_out     (image_ready_out),
      .image_size_out      (image_size_out),
      .timeout_out         (timeout_out)
   );

   always #5 clock_in = ~clock_in;

   function automatic logic [MAXC-1:0] span(input int lo, input int hi);
      logic [MAXC-1:0] v;
      v = '0;
      for (int i = lo; i <= hi; i++)
         if (i >= 0 && i < MAXC) v[i] = 1'b1;
      return v;
   endfunction

   function automatic string vec_msg(input string name, input logic [MAXC-1:0] act,
                                     input logic [MAXC-1:0] req);
      int idx;
      idx = -1;
      for (int i = 0; i < MAXC; i++)
         if (idx < 0 && act[i] !== req[i]) idx = i;
      if (idx < 0) idx = 0;
      return $sformatf("[TB] FAIL %s: first wrong cycle %0d, got %b required %b",
                       name, idx, act[idx], req[idx]);
   endfunction

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         st_rst[k]   = 1'b0;
         st_start[k] = 1'b0;
         st_ps[k]    = 1'b0;
         st_fv[k]    = 1'b0;
         st_jd[k]    = 1'b0;
         st_size[k]  = 16'($urandom);
         tr_size[k]  = '0;
      end
      tr_dphy  = '0;
      tr_prst  = '0;
      tr_en    = '0;
      tr_busy  = '0;
      tr_ready = '0;
      tr_tmo   = '0;
   endtask

   // Entry 0 is where the previous scenario's reset lands, so it is not recorded.
   task automatic run_stim(input int len);
      for (int k = 0; k < len; k++) begin
         @(posedge clock_in);
         #1;
         reset_in             = st_rst[k];
         start_capture_in     = st_start[k];
         power_save_enable_in = st_ps[k];
         frame_valid_in       = st_fv[k];
         jpeg_done_in         = st_jd[k];
         jpeg_size_in         = st_size[k];
         #1;
         if (k > 0) begin
            tr_dphy[k]  = dphy_power_down_out;
            tr_prst[k]  = pipeline_reset_out;
            tr_en[k]    = pipeline_enable_out;
            tr_busy[k]  = busy_out;
            tr_ready[k] = image_ready_out;
            tr_tmo[k]   = timeout_out;
            tr_size[k]  = image_size_out;
         end
      end
   endtask

   task automatic set_frame(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) st_fv[k] = 1'b1;
   endtask

   task automatic test_reset();
      clear_stim();
      st_rst[0] = 1'b1; st_start[0] = 1'b1;
      st_rst[1] = 1'b1; st_start[1] = 1'b1;
      run_stim(8);
      checks++;
      if (tr_busy !== span(0, -1)) begin failures++; $display("%s", vec_msg("reset_busy", tr_busy, span(0, -1))); end
      checks++;
      if ({tr_prst, tr_en, tr_dphy} !== {span(0, -1), span(0, -1), span(0, -1)}) begin
         failures++;
         $display("[TB] FAIL reset_phy_pipe: got prst=%b en=%b dphy=%b required all 0",
                  |tr_prst, |tr_en, |tr_dphy);
      end
      checks++;
      if ({tr_ready[3], tr_tmo[3], tr_size[3]} !== 18'd0) begin
         failures++;
         $display("[TB] FAIL reset_status: got ready=%b tmo=%b size=%h required 0 0 0000",
                  tr_ready[3], tr_tmo[3], tr_size[3]);
      end
   endtask

   task automatic test_basic_capture();
      for (int it = 0; it < 3; it++) begin
         int s, h0, len, e, d, n;
         logic [15:0] sz;
         clear_stim();
         if (it == 0) begin
            s = 10; h0 = 20; len = 100; e = h0 + len; d = e + 40; sz = 16'h1234;
         end else begin
            s = $urandom_range(5, 15);
            h0 = s + F + 1 + $urandom_range(1, 30);
            len = $urandom_range(1, 150);
            e = h0 + len;
            d = e + $urandom_range(1, 60);
            sz = 16'($urandom);
         end
         n = d + 4;
         st_rst[0] = 1'b1;
         st_jd[s-2] = 1'b1;
         st_start[s] = 1'b1;
         set_frame(h0, e - 1);
         st_jd[d] = 1'b1; st_size[d] = sz;
         run_stim(n);
         checks++;
         if (tr_prst !== span(s + 1, s + F)) begin failures++; $display("%s", vec_msg("basic_flush", tr_prst, span(s + 1, s + F))); end
         checks++;
         if (tr_en !== span(h0, e - 1)) begin failures++; $display("%s", vec_msg("basic_enable", tr_en, span(h0, e - 1))); end
         checks++;
         if (tr_busy !== span(s + 1, d)) begin failures++; $display("%s", vec_msg("basic_busy", tr_busy, span(s + 1, d))); end
         checks++;
         if (tr_ready !== span(d + 1, n - 1)) begin failures++; $display("%s", vec_msg("basic_ready", tr_ready, span(d + 1, n - 1))); end
         checks++;
         if ({tr_tmo, tr_dphy} !== {span(0, -1), span(0, -1)}) begin
            failures++; $display("[TB] FAIL basic_tmo_dphy: got tmo=%b dphy=%b required 0 0", |tr_tmo, |tr_dphy);
         end
         checks++;
         if (tr_size[s-1] !== 16'h0000) begin failures++; $display("[TB] FAIL idle_done_ignored: got %h required 0000", tr_size[s-1]); end
         checks++;
         if (tr_size[d+1] !== sz) begin failures++; $display("[TB] FAIL basic_size: got %h required %h", tr_size[d+1], sz); end
      end
   endtask

   task automatic test_mid_frame_start();
      for (int it = 0; it < 2; it++) begin
         int s, a1, b0, blen, d, n;
         logic [15:0] sz;
         clear_stim();
         s = $urandom_range(8, 15);
         a1 = s + $urandom_range(1, 40);
         b0 = ((a1 + 1 > s + F + 2) ? a1 + 1 : s + F + 2) + $urandom_range(0, 15);
         blen = $urandom_range(5, 60);
         d = b0 + blen + $urandom_range(1, 20);
         n = d + 4;
         sz = 16'($urandom);
         st_rst[0] = 1'b1;
         set_frame(2, a1 - 1);
         st_start[s] = 1'b1;
         set_frame(b0, b0 + blen - 1);
         st_jd[d] = 1'b1; st_size[d] = sz;
         run_stim(n);
         checks++;
         if (tr_en !== span(b0, b0 + blen - 1)) begin failures++; $display("%s", vec_msg("midframe_enable", tr_en, span(b0, b0 + blen - 1))); end
         checks++;
         if (tr_ready !== span(d + 1, n - 1)) begin failures++; $display("%s", vec_msg("midframe_ready", tr_ready, span(d + 1, n - 1))); end
         checks++;
         if (tr_size[d+1] !== sz) begin failures++; $display("[TB] FAIL midframe_size: got %h required %h", tr_size[d+1], sz); end
      end
   endtask

   task automatic test_power_save();
      for (int it = 0; it < 2; it++) begin
         int s, h0, e, d, n;
         logic [15:0] sz;
         clear_stim();
         s = $urandom_range(5, 15);
         h0 = s + S + F + 1 + $urandom_range(1, 20);
         e = h0 + $urandom_range(5, 60);
         d = e + $urandom_range(1, 30);
         n = d + 6;
         sz = 16'($urandom);
         st_rst[0] = 1'b1;
         for (int k = 1; k < n; k++) st_ps[k] = 1'b1;
         for (int k = s + 1; k < d; k++) if ($urandom_range(0, 3) == 0) st_ps[k] = 1'b0;
         st_start[s] = 1'b1;
         set_frame(h0, e - 1);
         st_jd[d] = 1'b1; st_size[d] = sz;
         run_stim(n);
         checks++;
         if (tr_dphy !== (span(2, s) | span(d + 2, n - 1))) begin
            failures++; $display("%s", vec_msg("ps_dphy", tr_dphy, span(2, s) | span(d + 2, n - 1)));
         end
         checks++;
         if (tr_prst !== span(s + 1 + S, s + S + F)) begin failures++; $display("%s", vec_msg("ps_flush", tr_prst, span(s + 1 + S, s + S + F))); end
         checks++;
         if (tr_en !== span(h0, e - 1)) begin failures++; $display("%s", vec_msg("ps_enable", tr_en, span(h0, e - 1))); end
         checks++;
         if (tr_busy !== span(s + 1, d)) begin failures++; $display("%s", vec_msg("ps_busy", tr_busy, span(s + 1, d))); end
         checks++;
         if (tr_size[d+1] !== sz) begin failures++; $display("[TB] FAIL ps_size: got %h required %h", tr_size[d+1], sz); end
      end
   endtask

   task automatic test_timeout();
      int s1, h0, e, d1, s2, x, s3, n;
      logic [15:0] sa;
      clear_stim();
      s1 = 5;
      h0 = s1 + F + 1 + $urandom_range(1, 10);
      e = h0 + $urandom_range(5, 30);
      d1 = e + $urandom_range(1, 10);
      s2 = d1 + $urandom_range(3, 8);
      x = s2 + F + T + 1;
      s3 = x + $urandom_range(2, 6);
      n = s3 + F + 3;
      sa = 16'($urandom);
      st_rst[0] = 1'b1;
      st_start[s1] = 1'b1;
      set_frame(h0, e - 1);
      st_jd[d1] = 1'b1; st_size[d1] = sa;
      st_start[s2] = 1'b1;
      st_jd[s2 + F + $urandom_range(5, 500)] = 1'b1;
      st_start[s3] = 1'b1;
      run_stim(n);
      checks++;
      if (tr_tmo !== span(x, s3)) begin failures++; $display("%s", vec_msg("timeout_flag", tr_tmo, span(x, s3))); end
      checks++;
      if (tr_busy !== (span(s1 + 1, d1) | span(s2 + 1, x - 1) | span(s3 + 1, n - 1))) begin
         failures++; $display("%s", vec_msg("timeout_busy", tr_busy, span(s1 + 1, d1) | span(s2 + 1, x - 1) | span(s3 + 1, n - 1)));
      end
      checks++;
      if (tr_ready !== span(d1 + 1, s2)) begin failures++; $display("%s", vec_msg("timeout_ready", tr_ready, span(d1 + 1, s2))); end
      checks++;
      if (tr_en !== span(h0, e - 1)) begin failures++; $display("%s", vec_msg("timeout_enable", tr_en, span(h0, e - 1))); end
      checks++;
      if (tr_prst !== (span(s1 + 1, s1 + F) | span(s2 + 1, s2 + F) | span(s3 + 1, s3 + F))) begin
         failures++; $display("%s", vec_msg("timeout_flush", tr_prst, span(s1 + 1, s1 + F) | span(s2 + 1, s2 + F) | span(s3 + 1, s3 + F)));
      end
      checks++;
      if (tr_size[x] !== sa) begin failures++; $display("[TB] FAIL timeout_size_kept: got %h required %h", tr_size[x], sa); end
   endtask

   task automatic test_timeout_done_race();
      for (int late = 0; late < 2; late++) begin
         int s, h0, e, q, n;
         logic [15:0] sz;
         clear_stim();
         s = $urandom_range(5, 10);
         h0 = s + F + 1 + $urandom_range(1, 10);
         e = h0 + $urandom_range(5, 50);
         q = s + F + T;
         n = q + 5;
         sz = 16'($urandom);
         st_rst[0] = 1'b1;
         st_start[s] = 1'b1;
         set_frame(h0, e - 1);
         st_jd[q + late] = 1'b1; st_size[q + late] = sz;
         run_stim(n);
         checks++;
         if (tr_busy !== span(s + 1, q)) begin failures++; $display("%s", vec_msg("race_busy", tr_busy, span(s + 1, q))); end
         if (late == 0) begin
            checks++;
            if ({tr_ready[q+1], tr_tmo[q+1]} !== 2'b10) begin
               failures++; $display("[TB] FAIL race_done_wins: got ready=%b tmo=%b required 1 0", tr_ready[q+1], tr_tmo[q+1]);
            end
            checks++;
            if (tr_size[q+1] !== sz) begin failures++; $display("[TB] FAIL race_size: got %h required %h", tr_size[q+1], sz); end
         end else begin
            checks++;
            if ({tr_ready[q+1], tr_tmo[q+1]} !== 2'b01) begin
               failures++; $display("[TB] FAIL race_late_done: got ready=%b tmo=%b required 0 1", tr_ready[q+1], tr_tmo[q+1]);
            end
            checks++;
            if (tr_size[n-1] !== 16'h0000) begin failures++; $display("[TB] FAIL race_late_size: got %h required 0000", tr_size[n-1]); end
         end
      end
   endtask

   task automatic test_restart_while_busy();
      for (int it = 0; it < 2; it++) begin
         int s, h0, r, h1, b0, blen, d, n;
         logic [15:0] sy;
         clear_stim();
         s = $urandom_range(5, 10);
         h0 = s + F + 1 + $urandom_range(1, 10);
         r = h0 + $urandom_range(2, 20);
         h1 = r + $urandom_range(1, 20);
         b0 = ((h1 + 1 > r + F + 2) ? h1 + 1 : r + F + 2) + $urandom_range(1, 10);
         blen = $urandom_range(5, 40);
         d = b0 + blen + $urandom_range(1, 15);
         n = d + 4;
         sy = 16'($urandom);
         st_rst[0] = 1'b1;
         st_start[s] = 1'b1;
         set_frame(h0, h1 - 1);
         st_start[r] = 1'b1;
         st_jd[b0 - 1] = 1'b1;
         set_frame(b0, b0 + blen - 1);
         st_jd[d] = 1'b1; st_size[d] = sy;
         run_stim(n);
         checks++;
         if (tr_prst !== (span(s + 1, s + F) | span(r + 1, r + F))) begin
            failures++; $display("%s", vec_msg("restart_flush", tr_prst, span(s + 1, s + F) | span(r + 1, r + F)));
         end
         checks++;
         if (tr_en !== (span(h0, r) | span(b0, b0 + blen - 1))) begin
            failures++; $display("%s", vec_msg("restart_enable", tr_en, span(h0, r) | span(b0, b0 + blen - 1)));
         end
         checks++;
         if (tr_busy !== span(s + 1, d)) begin failures++; $display("%s", vec_msg("restart_busy", tr_busy, span(s + 1, d))); end
         checks++;
         if (tr_ready !== span(d + 1, n - 1)) begin failures++; $display("%s", vec_msg("restart_ready", tr_ready, span(d + 1, n - 1))); end
         checks++;
         if (tr_size[b0] !== 16'h0000) begin failures++; $display("[TB] FAIL stray_done_ignored: got %h required 0000", tr_size[b0]); end
         checks++;
         if (tr_size[d+1] !== sy) begin failures++; $display("[TB] FAIL restart_size: got %h required %h", tr_size[d+1], sy); end
      end
   endtask

   task automatic test_reset_mid_encode();
      int s1, h0, e1, d1, s2, h2, e2, q, n;
      logic [15:0] sa;
      clear_stim();
      s1 = 5;
      h0 = s1 + F + 1 + $urandom_range(1, 10);
      e1 = h0 + $urandom_range(5, 30);
      d1 = e1 + $urandom_range(1, 10);
      s2 = d1 + 3;
      h2 = s2 + F + 1 + $urandom_range(1, 10);
      e2 = h2 + $urandom_range(5, 30);
      q = e2 + $urandom_range(1, 10);
      n = q + 6;
      sa = 16'($urandom);
      st_rst[0] = 1'b1;
      st_start[s1] = 1'b1;
      set_frame(h0, e1 - 1);
      st_jd[d1] = 1'b1; st_size[d1] = sa;
      st_start[s2] = 1'b1;
      set_frame(h2, e2 - 1);
      st_rst[q] = 1'b1;
      st_jd[q + 2] = 1'b1;
      run_stim(n);
      checks++;
      if (tr_size[q] !== sa) begin failures++; $display("[TB] FAIL pre_reset_size: got %h required %h", tr_size[q], sa); end
      checks++;
      if (tr_busy !== (span(s1 + 1, d1) | span(s2 + 1, q))) begin
         failures++; $display("%s", vec_msg("rst_enc_busy", tr_busy, span(s1 + 1, d1) | span(s2 + 1, q)));
      end
      checks++;
      if (tr_ready !== span(d1 + 1, s2)) begin failures++; $display("%s", vec_msg("rst_enc_ready", tr_ready, span(d1 + 1, s2))); end
      checks++;
      if (tr_en !== (span(h0, e1 - 1) | span(h2, e2 - 1))) begin
         failures++; $display("%s", vec_msg("rst_enc_enable", tr_en, span(h0, e1 - 1) | span(h2, e2 - 1)));
      end
      checks++;
      if ({tr_size[q+1], tr_size[n-1], tr_tmo[q+1], tr_dphy[q+1], tr_prst[q+1]} !== 35'd0) begin
         failures++;
         $display("[TB] FAIL rst_enc_outputs: got size=%h/%h tmo=%b dphy=%b prst=%b required 0",
                  tr_size[q+1], tr_size[n-1], tr_tmo[q+1], tr_dphy[q+1], tr_prst[q+1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_mid_frame_start();
      test_power_save();
      test_timeout();
      test_timeout_done_race();
      test_restart_while_busy();
      test_reset_mid_encode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
